// File: rtl/grid_adc_sched.sv
// ADC sample scheduler: per-channel block averaging into a 16-entry FWFT FIFO behind an Avalon-MM CSR port.
// Define GRID_ADC_SCHED_AVG_EN to build the averaging accumulators; otherwise every accepted sample is queued directly.
module grid_adc_sched (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_ctrl_address,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  input  logic [3:0]  asi_adc_channel,
  input  logic [15:0] asi_adc_data,
  input  logic        asi_adc_valid,
  output logic        asi_adc_ready,
  output logic        ins_irq_irq
);

  localparam logic [31:0] MOD_SIZE = 32'd32;
  localparam logic [31:0] MOD_ID   = 32'hEA68_0010;

  logic        enable_q;
  logic [2:0]  avg_log2;
  logic [15:0] ch_mask_q;
  logic [4:0]  irq_thresh_q;
  logic        overflow_q;
  logic [4:0]  level_q;
  logic [3:0]  wr_ptr_q, rd_ptr_q;
  logic [19:0] fifo_mem [16];
  logic [31:0] readdata_q, readdata_d;
  logic        irq_q;

  logic        wr_ctrl, wr_mask, wr_status, wr_thresh, cfg_wr, rd_fifo;
  logic        accept, push, do_push, do_pop, drop;
  logic [19:0] push_data;

  assign avs_ctrl_waitrequest = 1'b0;
  assign asi_adc_ready        = 1'b1;
  assign avs_ctrl_readdata    = readdata_q;
  assign ins_irq_irq          = irq_q;

  assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == 3'd2);
  assign wr_mask   = avs_ctrl_write && (avs_ctrl_address == 3'd3);
  assign wr_status = avs_ctrl_write && (avs_ctrl_address == 3'd4);
  assign wr_thresh = avs_ctrl_write && (avs_ctrl_address == 3'd6);
  assign rd_fifo   = avs_ctrl_read  && (avs_ctrl_address == 3'd5);
  assign cfg_wr    = wr_ctrl || wr_mask;

  // A configuration write wins over a coincident sample so no stale setting mixes into an average.
  assign accept = asi_adc_valid && enable_q && ch_mask_q[asi_adc_channel] && !cfg_wr;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      enable_q     <= 1'b0;
      ch_mask_q    <= 16'hFFFF;
      irq_thresh_q <= 5'd0;
    end else begin
      if (wr_ctrl && avs_ctrl_byteenable[0]) enable_q <= avs_ctrl_writedata[0];
      if (wr_mask) begin
        if (avs_ctrl_byteenable[0]) ch_mask_q[7:0]  <= avs_ctrl_writedata[7:0];
        if (avs_ctrl_byteenable[1]) ch_mask_q[15:8] <= avs_ctrl_writedata[15:8];
      end
      if (wr_thresh && avs_ctrl_byteenable[0]) irq_thresh_q <= avs_ctrl_writedata[4:0];
    end
  end

`ifdef GRID_ADC_SCHED_AVG_EN
  logic [2:0]  avg_log2_q;
  logic [22:0] acc_q [16];
  logic [7:0]  cnt_q [16];
  logic [22:0] acc_sum, acc_shifted;
  logic [7:0]  cnt_next;
  logic        avg_done;

  assign avg_log2    = avg_log2_q;
  assign acc_sum     = acc_q[asi_adc_channel] + {7'd0, asi_adc_data};
  assign acc_shifted = acc_sum >> avg_log2_q;
  assign cnt_next    = cnt_q[asi_adc_channel] + 8'd1;
  assign avg_done    = (cnt_next == (8'd1 << avg_log2_q));
  assign push        = accept && avg_done;
  assign push_data   = {asi_adc_channel, acc_shifted[15:0]};

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      avg_log2_q <= 3'd0;
      for (int i = 0; i < 16; i++) begin
        acc_q[i] <= 23'd0;
        cnt_q[i] <= 8'd0;
      end
    end else if (cfg_wr) begin
      if (wr_ctrl && avs_ctrl_byteenable[1]) avg_log2_q <= avs_ctrl_writedata[10:8];
      for (int i = 0; i < 16; i++) begin
        acc_q[i] <= 23'd0;
        cnt_q[i] <= 8'd0;
      end
    end else if (accept) begin
      // A completed block clears its channel even when the FIFO drops the result.
      acc_q[asi_adc_channel] <= avg_done ? 23'd0 : acc_sum;
      cnt_q[asi_adc_channel] <= avg_done ? 8'd0  : cnt_next;
    end
  end
`else
  assign avg_log2  = 3'd0;
  assign push      = accept;
  assign push_data = {asi_adc_channel, asi_adc_data};
`endif

  assign do_pop  = rd_fifo && (level_q != 5'd0);
  assign do_push = push && ((level_q != 5'd16) || do_pop);
  assign drop    = push && (level_q == 5'd16) && !do_pop;

  // NOTE: FIFO storage has no reset; level and pointers alone define which entries are valid.
  always_ff @(posedge csi_MCLK_clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      wr_ptr_q   <= 4'd0;
      rd_ptr_q   <= 4'd0;
      level_q    <= 5'd0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 4'd1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 4'd1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 5'd1;
        2'b01:   level_q <= level_q - 5'd1;
        default: level_q <= level_q;
      endcase
      if (drop)
        overflow_q <= 1'b1;
      else if (wr_status && avs_ctrl_byteenable[1] && avs_ctrl_writedata[8])
        overflow_q <= 1'b0;
    end
  end

  always_comb begin
    readdata_d = 32'd0;
    case (avs_ctrl_address)
      3'd0: readdata_d = MOD_SIZE;
      3'd1: readdata_d = MOD_ID;
      3'd2: readdata_d = {21'd0, avg_log2, 7'd0, enable_q};
      3'd3: readdata_d = {16'd0, ch_mask_q};
      3'd4: readdata_d = {15'd0, (level_q == 5'd0), 7'd0, overflow_q, 3'd0, level_q};
      3'd5: readdata_d = (level_q != 5'd0) ? {12'd0, fifo_mem[rd_ptr_q]} : 32'd0;
      3'd6: readdata_d = {27'd0, irq_thresh_q};
      default: readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      if (avs_ctrl_read) readdata_q <= readdata_d;
      irq_q <= ((irq_thresh_q != 5'd0) && (level_q >= irq_thresh_q)) || overflow_q;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{avs_ctrl_writedata[31:16], avs_ctrl_byteenable[3:2]};

endmodule

// File: tb/tb_grid_adc_sched.sv
// Directed bench for grid_adc_sched: a CSR/sample vector table plus hand sequences for FIFO-full and averaging corners.
// Averaging sequences are compiled in only when GRID_ADC_SCHED_AVG_EN is defined.
module tb_grid_adc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        wr, rd;
  logic [31:0] rdata;
  logic        waitreq;
  logic [3:0]  ch;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grid_adc_sched dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avs_ctrl_address     (addr),
    .avs_ctrl_writedata   (wdata),
    .avs_ctrl_byteenable  (be),
    .avs_ctrl_write       (wr),
    .avs_ctrl_read        (rd),
    .avs_ctrl_readdata    (rdata),
    .avs_ctrl_waitrequest (waitreq),
    .asi_adc_channel      (ch),
    .asi_adc_data         (data),
    .asi_adc_valid        (valid),
    .asi_adc_ready        (ready),
    .ins_irq_irq          (irq)
  );

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_SMP} op_e;
  typedef struct {
    op_e         op;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  ch;
    logic [31:0] exp;
  } vec_t;

`ifdef GRID_ADC_SCHED_AVG_EN
  localparam logic [31:0] CTRL_AVG7_RB = 32'h0000_0701;
`else
  localparam logic [31:0] CTRL_AVG7_RB = 32'h0000_0001;
`endif

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; be = 4'hF; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic send(input logic [3:0] c, input logic [15:0] d);
    ch = c; data = d; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic expect_rd(input string name, input logic [2:0] a, input logic [31:0] e);
    logic [31:0] r;
    csr_read(a, r);
    check(name, r, e);
  endtask

  function automatic vec_t mk(op_e op, logic [2:0] a, logic [31:0] d, logic [3:0] c, logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.ch = c; v.exp = e;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] model[$];

    addr = 3'd0; wdata = 32'd0; be = 4'hF; wr = 1'b0; rd = 1'b0;
    ch = 4'd0; data = 16'd0; valid = 1'b0;

    // Reset values and the basic single-sample path.
    vecs.push_back(mk(OP_RD,  3'd0, 0, 0, 32'd32));
    vecs.push_back(mk(OP_RD,  3'd1, 0, 0, 32'hEA68_0010));
    vecs.push_back(mk(OP_RD,  3'd2, 0, 0, 32'h0));
    vecs.push_back(mk(OP_RD,  3'd3, 0, 0, 32'h0000_FFFF));
    vecs.push_back(mk(OP_RD,  3'd4, 0, 0, 32'h0001_0000));
    vecs.push_back(mk(OP_RD,  3'd6, 0, 0, 32'h0));
    vecs.push_back(mk(OP_RD,  3'd7, 0, 0, 32'h0));
    vecs.push_back(mk(OP_RD,  3'd5, 0, 0, 32'h0));
    vecs.push_back(mk(OP_RD,  3'd4, 0, 0, 32'h0001_0000));
    vecs.push_back(mk(OP_SMP, 0, 32'h1111, 4'd3, 0));
    vecs.push_back(mk(OP_RD,  3'd4, 0, 0, 32'h0001_0000));
    vecs.push_back(mk(OP_WR,  3'd2, 32'h1, 0, 0));
    vecs.push_back(mk(OP_SMP, 0, 32'h1230, 4'd3, 0));
    vecs.push_back(mk(OP_RD,  3'd4, 0, 0, 32'h0000_0001));
    vecs.push_back(mk(OP_RD,  3'd5, 0, 0, 32'h0003_1230));
    vecs.push_back(mk(OP_RD,  3'd4, 0, 0, 32'h0001_0000));
    vecs.push_back(mk(OP_WR,  3'd2, 32'h701, 0, 0));
    vecs.push_back(mk(OP_RD,  3'd2, 0, 0, CTRL_AVG7_RB));
    vecs.push_back(mk(OP_WR,  3'd2, 32'h0, 0, 0));
    vecs.push_back(mk(OP_SMP, 0, 32'hAAAA, 4'd1, 0));
    vecs.push_back(mk(OP_RD,  3'd4, 0, 0, 32'h0001_0000));
    vecs.push_back(mk(OP_WR,  3'd2, 32'h1, 0, 0));
    vecs.push_back(mk(OP_WR,  3'd3, 32'h0001, 0, 0));
    vecs.push_back(mk(OP_RD,  3'd3, 0, 0, 32'h0000_0001));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(OP_SMP, 0, 32'h0100 + i, 4'd0, 0));
      vecs.push_back(mk(OP_SMP, 0, 32'h0200 + i, 4'd1, 0));
    end
    vecs.push_back(mk(OP_RD, 3'd4, 0, 0, 32'h0000_0008));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(OP_RD, 3'd5, 0, 0, 32'h0000_0100 + i));
    vecs.push_back(mk(OP_RD, 3'd4, 0, 0, 32'h0001_0000));

    rst = 1'b1;
    #1;
    check("reset_readdata", rdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    check("waitrequest_tied", {31'd0, waitreq}, 32'h0);
    check("ready_tied", {31'd0, ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:  csr_write(vecs[i].addr, vecs[i].data);
        OP_SMP: send(vecs[i].ch, vecs[i].data[15:0]);
        default: begin
          csr_read(vecs[i].addr, r);
          check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), r, vecs[i].exp);
        end
      endcase
    end

    // A sample coinciding with a CH_MASK write is not accepted.
    addr = 3'd3; wdata = 32'hFFFF; be = 4'hF; wr = 1'b1;
    ch = 4'd9; data = 16'h5555; valid = 1'b1;
    tick();
    wr = 1'b0; valid = 1'b0;
    expect_rd("cfg_write_blocks_sample", 3'd4, 32'h0001_0000);

    // Fill past full: 17 results, last one dropped.
    csr_write(3'd6, 32'd16);
    for (int i = 0; i < 17; i++) send(4'd7, 16'(i));
    expect_rd("full_status", 3'd4, 32'h0000_0110);
    tick();
    check("irq_on_overflow", {31'd0, irq}, 32'h1);
    csr_write(3'd4, 32'h100);
    expect_rd("overflow_cleared", 3'd4, 32'h0000_0010);
    tick();
    check("irq_level_at_thresh", {31'd0, irq}, 32'h1);
    csr_write(3'd6, 32'd0);
    tick();
    tick();
    check("irq_thresh_zero", {31'd0, irq}, 32'h0);
    expect_rd("head_after_overflow", 3'd5, 32'h0007_0000);
    send(4'd7, 16'h00A5);
    expect_rd("refilled_status", 3'd4, 32'h0000_0010);

    // Push and pop in the same cycle at level 16.
    ch = 4'd7; data = 16'hBEEF; valid = 1'b1;
    addr = 3'd5; rd = 1'b1;
    tick();
    valid = 1'b0; rd = 1'b0;
    check("simul_pop_data", rdata, 32'h0007_0001);
    expect_rd("simul_status", 3'd4, 32'h0000_0010);

    for (int i = 2; i < 16; i++) model.push_back(16'(i));
    model.push_back(16'h00A5);
    model.push_back(16'hBEEF);
    foreach (model[i]) expect_rd($sformatf("drain%0d", i), 3'd5, {12'd0, 4'd7, model[i]});
    expect_rd("drained_status", 3'd4, 32'h0001_0000);

`ifdef GRID_ADC_SCHED_AVG_EN
    // Four-sample average on ch5.
    csr_write(3'd2, 32'h201);
    send(4'd5, 16'h1000);
    send(4'd5, 16'h2000);
    send(4'd5, 16'h3000);
    expect_rd("avg4_not_yet", 3'd4, 32'h0001_0000);
    send(4'd5, 16'h4000);
    expect_rd("avg4_pushed", 3'd4, 32'h0000_0001);
    expect_rd("avg4_value", 3'd5, 32'h0005_2800);

    // A CTRL write discards the partial block on ch2.
    csr_write(3'd2, 32'h301);
    for (int i = 0; i < 5; i++) send(4'd2, 16'hFFFF);
    csr_write(3'd2, 32'h301);
    for (int i = 0; i < 7; i++) send(4'd2, 16'h0800);
    expect_rd("avg8_not_yet", 3'd4, 32'h0001_0000);
    send(4'd2, 16'h0800);
    expect_rd("avg8_status", 3'd4, 32'h0000_0001);
    expect_rd("avg8_value", 3'd5, 32'h0002_0800);

    // Reset mid-accumulation discards the partial sum.
    csr_write(3'd2, 32'h101);
    send(4'd4, 16'h4000);
    do_reset();
    expect_rd("post_reset_ctrl", 3'd2, 32'h0);
    csr_write(3'd2, 32'h101);
    send(4'd4, 16'h2000);
    expect_rd("post_reset_no_entry", 3'd4, 32'h0001_0000);
    send(4'd4, 16'h2000);
    expect_rd("post_reset_avg", 3'd5, 32'h0004_2000);
`else
    // Reset clears enable and FIFO state.
    send(4'd4, 16'h4000);
    do_reset();
    expect_rd("post_reset_ctrl", 3'd2, 32'h0);
    expect_rd("post_reset_status", 3'd4, 32'h0001_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_adc_sched.md
GRID_ADC_SCHED -- requirements
Module: grid_adc_sched

Interface
REQ-001 SHALL provide: csi_MCLK_clk  in  1  system clock; all logic is synchronous to it, and the ADC stream is sampled on it.
REQ-002 SHALL provide: rsi_MRST_reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: avs_ctrl_address  in  3  CSR word address.
REQ-004 SHALL provide: avs_ctrl_writedata  in  32  write data; avs_ctrl_byteenable  in  4  byte lanes.
REQ-005 SHALL provide: avs_ctrl_write, avs_ctrl_read  in  1  strobes.
REQ-006 SHALL provide: avs_ctrl_readdata  out  32  registered read data; avs_ctrl_waitrequest  out  1  tied 0.
REQ-007 SHALL provide: asi_adc_channel  in  4  sample channel; asi_adc_data  in  16  left-justified sample; asi_adc_valid  in  1  sample strobe.
REQ-008 SHALL provide: asi_adc_ready  out  1  tied 1; the block never back-pressures.
REQ-009 SHALL provide: ins_irq_irq  out  1  level interrupt.

Function
REQ-010 CSR map, one entry per word address:
- 0 MOD_SIZE: reads 32.
- 1 MOD_ID: reads 0xEA680010.
- 2 CTRL: bit0 enable; bits10:8 avg_log2; writes use byte lanes 0 and 1.
- 3 CH_MASK: bits15:0.
- 4 STATUS: bits4:0 fifo level; bit8 overflow, write-1-to-clear; bit16 empty.
- 5 FIFO: bits19:16 channel; bits15:0 average.
- 6 IRQ_THRESH: bits4:0.
- 7: reads 0.
REQ-011 Readdata SHALL be valid on the cycle after avs_ctrl_read.
REQ-012 A sample SHALL be accepted iff asi_adc_valid && enable && CH_MASK[asi_adc_channel] and no CTRL/CH_MASK write occurs that cycle.
REQ-013 Per channel: 23-bit accumulator plus 8-bit count; an accepted sample SHALL add asi_adc_data to the accumulator and increment the count.
REQ-014 When the count reaches 2^avg_log2, the same cycle SHALL compute (acc + sample) >> avg_log2, truncated to 16 bits, push {channel, result} into the FIFO and clear that channel's accumulator and count. Push latency is 1 cycle from acceptance.
REQ-015 FIFO SHALL be 16 entries, first-word-fall-through. Level SHALL range 0..16.
REQ-016 A read of address 5 SHALL return the head entry and pop it in the read cycle.
REQ-017 A read of address 5 while empty SHALL return 0 and leave level 0.
REQ-018 On push while level=16 with no simultaneous pop, the result SHALL be dropped, overflow set sticky, and the accumulator still cleared.
REQ-019 Push and pop in the same cycle SHALL both take effect, level unchanged; at level 16 no overflow SHALL be flagged.
REQ-020 Any write to CTRL or CH_MASK SHALL clear all 16 accumulators and counts. It SHALL NOT affect FIFO contents.
REQ-021 ins_irq_irq SHALL be registered and equal (IRQ_THRESH!=0 && level>=IRQ_THRESH) || overflow.
REQ-022 Clearing enable SHALL stop acceptance the next cycle. FIFO SHALL remain readable.

Reset
REQ-023 Reset SHALL clear the following, asynchronously:
- CSRs: enable=0, avg_log2=0, CH_MASK=0xFFFF, IRQ_THRESH=0.
- Status: overflow=0.
- FIFO: level=0.
- Datapath: accumulators and counts cleared.
- Outputs: readdata=0, ins_irq_irq=0.
REQ-024 Reset mid-accumulation SHALL discard partial sums. No FIFO entry SHALL be produced.

Configuration
REQ-025 Macro GRID_ADC_SCHED_AVG_EN defined: averaging is per REQ-013/014, with avg_log2 0..7 (1..128 samples).
REQ-026 Macro undefined: no accumulators are built. avg_log2 SHALL read 0 and ignore writes. Every accepted sample is pushed directly, latency 1.

Verification
REQ-027 Reset, enable=1, avg_log2=0; send ch3 data 0x1230 -> FIFO read returns 0x00031230; STATUS empty=1 afterwards.
REQ-028 avg_log2=2 (AVG_EN); ch5 samples 0x1000, 0x2000, 0x3000, 0x4000 -> exactly one entry 0x00052800, pushed the cycle after the 4th sample.
REQ-029 CH_MASK=0x0001; send ch0 and ch1 alternately, 8 each, avg_log2=0 -> 8 entries, all channel 0.
REQ-030 Fill 17 results without reads -> level=16, overflow=1, irq=1; write STATUS bit8=1 -> overflow=0; irq stays 1 only if IRQ_THRESH<=16 and nonzero.
REQ-031 At level 16, push and FIFO read in the same cycle -> level stays 16, overflow stays 0.
REQ-032 avg_log2=3; send 5 samples on ch2, write CTRL, send 8 samples of 0x0800 -> single entry 0x00020800.
